// File: rtl/serial_adder_ctrl_pkg.sv
// Shared encodings for the bit-serial add/subtract path.
// Op codes and controller state codes.
package serial_adder_ctrl_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// One-bit full adder shared by the serial datapath.
// Purely combinational.
module fulladder (
  output logic s,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  // sum and carry of one bit position
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller, one bit per cycle.
// Result, carry and overflow registered until next completion.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sr_shift;

  fulladder u_fa (
    .s    (fa_s),
    .cout (fa_co),
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q)
  );

  // sum bit enters at the MSB as the register shifts right
  always_comb begin
    sr_shift = sr_q >> 1;
    sr_shift[WIDTH-1] = fa_s;
  end

  // sequencing; the unused state code behaves like IDLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_RUN: begin
        sr_d    = sr_shift;
        carry_d = fa_co;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = sr_shift;
          cout_d   = fa_co;
          ovf_d    = carry_q ^ fa_co;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          sa_d    = a;
          sb_d    = (op == ALU_OP_SUB) ? ~b : b;
          carry_d = (op == ALU_OP_SUB);
          cnt_d   = '0;
        end
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl.
// Reference model uses plain integer arithmetic.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       overflow;

  int nvec;
  int nerr;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {overflow, cout, result}
  function automatic logic [9:0] ref_alu(input logic o,
                                         input logic [7:0] x,
                                         input logic [7:0] y);
    int ux, uy, full, sx, sy, sv;
    logic [7:0] r;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    full = o ? ux + (255 - uy) + 1 : ux + uy;
    sv = o ? sx - sy : sx + sy;
    r = 8'(full % 256);
    c = (full >= 256);
    v = (sv < -128) || (sv > 127);
    return {v, c, r};
  endfunction

  // called at a negedge with the DUT idle; returns at a negedge, idle
  task automatic run_op(input logic o, input logic [7:0] x,
                        input logic [7:0] y, input string tag);
    int bc;
    int k;
    bit seen;
    logic [9:0] e;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 1'($urandom);
    a = 8'($urandom);
    b = 8'($urandom);
    bc = 0;
    seen = 0;
    k = 0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      k++;
      if (busy && done) check({tag, ":busy_and_done"}, 1, 0);
      if (busy) bc++;
      if (done) seen = 1;
    end
    check({tag, ":done_seen"}, 32'(seen), 1);
    check({tag, ":latency"}, 32'(k), 9);
    check({tag, ":busy_cycles"}, 32'(bc), 8);
    e = ref_alu(o, x, y);
    check({tag, ":result"}, 32'(result), 32'(e[7:0]));
    check({tag, ":cout"}, 32'(cout), 32'(e[8]));
    check({tag, ":overflow"}, 32'(overflow), 32'(e[9]));
    @(negedge clk);
    check({tag, ":done_once"}, 32'(done), 0);
  endtask

  initial begin
    int nd;
    int last_done;
    logic [16:0] hist [0:63];
    logic [16:0] h;
    logic [9:0] e;
    logic [7:0] ra, rb;
    logic ro;

    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    start = 1'b1;
    op = 1'b0;
    a = 8'hFF;
    b = 8'h01;

    repeat (3) @(negedge clk);
    check("rst:busy", 32'(busy), 0);
    check("rst:done", 32'(done), 0);
    check("rst:result", 32'(result), 0);
    check("rst:cout", 32'(cout), 0);
    check("rst:ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle:busy", 32'(busy), 0);
    end

    run_op(1'b0, 8'h05, 8'h03, "add5_3");
    run_op(1'b0, 8'hFF, 8'h01, "addFF_1");
    run_op(1'b0, 8'h7F, 8'h01, "add7F_1");
    run_op(1'b1, 8'h03, 8'h05, "sub3_5");
    run_op(1'b1, 8'h80, 8'h01, "sub80_1");
    run_op(1'b1, 8'h00, 8'h00, "sub0_0");

    // start pulsed mid-run must be ignored
    start = 1'b1;
    op = 1'b0;
    a = 8'h10;
    b = 8'h20;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    op = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("ign:done_count", 32'(nd), 1);
    check("ign:result", 32'(result), 32'h30);

    // start held high: accept every WIDTH+2 cycles
    nd = 0;
    last_done = -1;
    for (int m = 0; m < 48; m++) begin
      if (m > 0) @(negedge clk);
      if (done) begin
        nd++;
        if (m >= 9) begin
          h = hist[m - 9];
          e = ref_alu(h[16], h[15:8], h[7:0]);
          check("b2b:result", 32'(result), 32'(e[7:0]));
          check("b2b:cout", 32'(cout), 32'(e[8]));
          check("b2b:ovf", 32'(overflow), 32'(e[9]));
        end else begin
          check("b2b:early_done", 32'(m), 9);
        end
        if (last_done >= 0)
          check("b2b:interval", 32'(m - last_done), 10);
        last_done = m;
      end
      ro = 1'($urandom);
      ra = 8'($urandom);
      rb = 8'($urandom);
      hist[m] = {ro, ra, rb};
      start = 1'b1;
      op = ro;
      a = ra;
      b = rb;
    end
    start = 1'b0;
    check("b2b:done_count", 32'(nd), 4);
    repeat (12) @(negedge clk);

    // reset in the middle of an operation
    run_op(1'b0, 8'h05, 8'h03, "pre_abort");
    start = 1'b1;
    op = 1'b0;
    a = 8'h01;
    b = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort:busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort:result", 32'(result), 0);
    check("abort:busy", 32'(busy), 0);
    check("abort:done", 32'(done), 0);
    check("abort:cout", 32'(cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("abort:no_activity", 32'(nd), 0);
    run_op(1'b0, 8'h01, 8'h01, "add1_1");

    // random operations
    for (int i = 0; i < 40; i++)
      run_op(1'($urandom), 8'($urandom), 8'($urandom), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
